// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int MIN_LEN = 2;

    // Keeps a run-time pattern length inside the range the history register supports.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len < int'(MIN_LEN))
            return int'(MIN_LEN);
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_det_prog.sv
// Programmable-pattern Mealy sequence detector with valid-qualified serial input.
// Optional match counter is built only when SEQ_DET_CNT_EN is defined; otherwise match_cnt is 0.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               dout,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    state_t             state;
    logic [MAX_LEN-2:0] history;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len_r;
    logic [MAX_LEN-1:0] pattern_r;
    logic               overlap_r;
    logic               armed_r;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               match;

    assign window = {history, din};

    // Only the low len_r bits of the window take part in the comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_r));
    end

    assign match = din_valid && (state == HUNT) && (((window ^ pattern_r) & mask) == '0);
    assign dout  = match && !cfg_load && !reset;
    assign armed = armed_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            history   <= '0;
            fill      <= '0;
            len_r     <= '0;
            pattern_r <= '0;
            overlap_r <= 1'b0;
            armed_r   <= 1'b0;
        end else if (cfg_load) begin
            state     <= FILL;
            history   <= '0;
            fill      <= '0;
            len_r     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            pattern_r <= cfg_pattern;
            overlap_r <= cfg_overlap;
            armed_r   <= 1'b1;
        end else if (din_valid) begin
            case (state)
                FILL: begin
                    history <= window[MAX_LEN-2:0];
                    fill    <= fill + LEN_W'(1);
                    if (fill == len_r - LEN_W'(MIN_LEN))
                        state <= HUNT;
                end
                HUNT: begin
                    // Non-overlapping mode consumes the terminating bit and refills from scratch.
                    if (match && !overlap_r) begin
                        history <= '0;
                        fill    <= '0;
                        state   <= FILL;
                    end else begin
                        history <= window[MAX_LEN-2:0];
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || cfg_load)
            cnt <= '0;
        else if (dout && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog (default counter width and a 2-bit counter copy).
module tb_seq_det_prog;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       dout, dout2, armed, armed2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;

    seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .dout(dout), .armed(armed), .match_cnt(match_cnt)
    );

    seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .dout(dout2), .armed(armed2), .match_cnt(match_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied after the falling edge, dout checked mid-low-phase.
    task automatic cyc(input logic rs, input logic ld, input logic v, input logic d,
                       input logic exp_dout, input string tag);
        @(negedge clk);
        reset = rs; cfg_load = ld; din_valid = v; din = d;
        #1;
        chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        chk({tag, "_dout2"}, 32'(dout2), 32'(exp_dout));
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input string tag);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {tag, "_load"});
        chk({tag, "_armed"}, 32'(armed), 32'd1);
        chk({tag, "_cnt_clr"}, 32'(match_cnt), 32'd0);
    endtask

    // Bits streamed first-to-last from bits[n-1] down to bits[0].
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                          input string tag);
        for (int i = n - 1; i >= 0; i--)
            cyc(1'b0, 1'b0, 1'b1, bits[i], exp[i], tag);
    endtask

    task automatic chk_cnt(input int n, input string tag);
        int e8, e2;
        e8 = CNT_EN ? ((n > 255) ? 255 : n) : 0;
        e2 = CNT_EN ? ((n > 3) ? 3 : n) : 0;
        chk({tag, "_cnt"}, 32'(match_cnt), 32'(e8));
        chk({tag, "_cnt2"}, 32'(match_cnt2), 32'(e2));
    endtask

    initial begin
        // Reset held with random valid bits, then idle stream ignored.
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "rst");
        chk("rst_armed", 32'(armed), 32'd0);
        chk_cnt(0, "rst");
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "idle");
        chk("idle_armed", 32'(armed), 32'd0);
        chk_cnt(0, "idle");

        // 1001 overlapping; upper pattern bits are junk and must be ignored.
        load(8'b1110_1001, 4'd4, 1'b1, "ov");
        stream(16'b0_0100_1001, 16'b0_0000_1001, 9, "ov");
        chk_cnt(2, "ov");

        // Same stream, non-overlapping: bits 7..9 only refill.
        load(8'b1110_1001, 4'd4, 1'b0, "nov");
        stream(16'b0_0100_1001, 16'b0_0000_1000, 9, "nov");
        chk_cnt(1, "nov");

        // 8-bit pattern with idle gaps carrying the complemented bit.
        load(8'b1011_0111, 4'd8, 1'b1, "gap");
        begin
            logic [7:0] p;
            p = 8'b1011_0111;
            for (int i = 7; i >= 0; i--) begin
                cyc(1'b0, 1'b0, 1'b1, p[i], (i == 0), "gap_bit");
                cyc(1'b0, 1'b0, 1'b0, ~p[i], 1'b0, "gap_idle");
            end
        end
        chk_cnt(1, "gap");

        // cfg_load collides with a matching final bit.
        load(8'b0000_1001, 4'd4, 1'b1, "col");
        stream(16'b10_0100, 16'b00_0100, 6, "col_pre");
        chk_cnt(1, "col_pre");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "col_hit");
        chk_cnt(0, "col_hit");
        chk("col_armed", 32'(armed), 32'd1);
        stream(16'b1001, 16'b0001, 4, "col_post");
        chk_cnt(1, "col_post");

        // Length 1 clamps to 2.
        load(8'b0000_0010, 4'd1, 1'b1, "len1");
        stream(16'b1_0010, 16'b0_1001, 5, "len1");
        chk_cnt(2, "len1");

        // Length 15 clamps to 8.
        load(8'b1011_0111, 4'd15, 1'b0, "len15");
        stream(16'b1011_0111, 16'b0000_0001, 8, "len15");
        chk_cnt(1, "len15");

        // Six matches: 8-bit counter reaches 6, 2-bit counter saturates at 3.
        load(8'b0000_0010, 4'd2, 1'b1, "sat");
        stream(16'b1010_1010_1010, 16'b0101_0101_0101, 12, "sat");
        chk_cnt(6, "sat");

        // Reset mid-HUNT with a matching bit present.
        load(8'b0000_1001, 4'd4, 1'b1, "mrst");
        stream(16'b100, 16'b000, 3, "mrst_pre");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "mrst_hit");
        chk("mrst_armed", 32'(armed), 32'd0);
        chk("mrst_armed2", 32'(armed2), 32'd0);
        chk_cnt(0, "mrst");
        stream(16'b1001, 16'b0000, 4, "mrst_post");
        chk_cnt(0, "mrst_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
